// File: rtl/ldm_stm_sequencer_if.sv
`default_nettype none
// ============================================================================
// ldm_stm_sequencer_if : decoder / AHB-side signal bundle for the LDM/STM
//                        block-transfer sequencer.
// Rev 1.0
// ============================================================================
interface ldm_stm_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [15:0]       reg_list;
    logic [3:0]        rn;
    logic [ADDR_W-1:0] base;
    logic              ldr_p;
    logic              ldr_u;
    logic              ldr_w;
    logic              ldr_l;
    logic              bus_ready;
    logic              busy;
    logic              AHB_rd_en;
    logic              AHB_wr_en;
    logic [ADDR_W-1:0] AHB_addr;
    logic [3:0]        xfer_reg;
    logic              wb_en;
    logic [4:0]        wb_id;
    logic [ADDR_W-1:0] wb_data;
    logic              done;
    logic              branch;

    modport master (
        output start, reg_list, rn, base, ldr_p, ldr_u, ldr_w, ldr_l, bus_ready,
        input  busy, AHB_rd_en, AHB_wr_en, AHB_addr, xfer_reg,
               wb_en, wb_id, wb_data, done, branch
    );

    modport slave (
        input  start, reg_list, rn, base, ldr_p, ldr_u, ldr_w, ldr_l, bus_ready,
        output busy, AHB_rd_en, AHB_wr_en, AHB_addr, xfer_reg,
               wb_en, wb_id, wb_data, done, branch
    );
endinterface
`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// ldm_stm_sequencer : multi-cycle LDM/STM beat sequencer with base writeback.
// Optional macro LDMSEQ_PC_LOAD_EN enables the R15-load branch flag.
// Rev 1.0
// ============================================================================
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ldm_stm_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_WB     = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_list;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_final;
    logic [3:0]        r_rn;
    logic              r_l;
    logic              r_wb;

    logic [4:0]        w_n;
    logic [ADDR_W-1:0] w_n4;
    logic [ADDR_W-1:0] w_first;
    logic [ADDR_W-1:0] w_final;
    logic [3:0]        w_cur_reg;
    logic              w_last;
    logic              w_accept;
    logic              w_launch;

    always_comb begin
        w_n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_n = w_n + 5'(bus.reg_list[i]);
        end
    end

    assign w_n4 = ADDR_W'({w_n, 2'b00});

    // Beats always run upward; decrement modes just start lower.
    always_comb begin
        case ({bus.ldr_p, bus.ldr_u})
            2'b01:   w_first = bus.base;
            2'b11:   w_first = bus.base + ADDR_W'(4);
            2'b00:   w_first = bus.base - w_n4 + ADDR_W'(4);
            default: w_first = bus.base - w_n4;
        endcase
    end

    assign w_final = bus.ldr_u ? (bus.base + w_n4) : (bus.base - w_n4);

    always_comb begin
        w_cur_reg = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_list[i]) begin
                w_cur_reg = 4'(i);
            end
        end
    end

    assign w_last   = ((r_list & (r_list - 16'd1)) == 16'd0);
    assign w_accept = (r_state == S_XFER) && bus.bus_ready;
    assign w_launch = (r_state == S_IDLE) && bus.start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (w_n != 5'd0) ? S_XFER : S_FINISH;
                end
            end
            S_XFER: begin
                if (bus.bus_ready && w_last) begin
                    w_next = r_wb ? S_WB : S_FINISH;
                end
            end
            S_WB:     w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_list  <= 16'd0;
            r_addr  <= '0;
            r_final <= '0;
            r_rn    <= 4'd0;
            r_l     <= 1'b0;
            r_wb    <= 1'b0;
        end else if (w_launch) begin
            r_list  <= bus.reg_list;
            r_addr  <= w_first;
            r_final <= w_final;
            r_rn    <= bus.rn;
            r_l     <= bus.ldr_l;
            // A loaded Rn overrides the writeback; an empty list never writes back.
            r_wb    <= bus.ldr_w && (w_n != 5'd0) && !(bus.ldr_l && bus.reg_list[bus.rn]);
        end else if (w_accept) begin
            r_list  <= r_list & (r_list - 16'd1);
            r_addr  <= r_addr + ADDR_W'(4);
        end
    end

`ifdef LDMSEQ_PC_LOAD_EN
    logic r_branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch <= 1'b0;
        end else if (r_state == S_FINISH) begin
            r_branch <= 1'b0;
        end else if (w_accept && r_l && (w_cur_reg == 4'd15)) begin
            r_branch <= 1'b1;
        end
    end

    assign bus.branch = r_branch;
`else
    assign bus.branch = 1'b0;
`endif

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.AHB_rd_en = (r_state == S_XFER) && r_l;
    assign bus.AHB_wr_en = (r_state == S_XFER) && !r_l;
    assign bus.AHB_addr  = (r_state == S_XFER) ? r_addr : '0;
    assign bus.xfer_reg  = (r_state == S_XFER) ? w_cur_reg : 4'd0;
    assign bus.wb_en     = (r_state == S_WB);
    assign bus.wb_id     = (r_state == S_WB) ? {1'b0, r_rn} : 5'd0;
    assign bus.wb_data   = (r_state == S_WB) ? r_final : '0;
    assign bus.done      = (r_state == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ldm_stm_sequencer : directed + randomized bench against a transaction-level
//                        model of LDM/STM block transfers.
// Rev 1.0
// ============================================================================
module tb_ldm_stm_sequencer;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ldm_stm_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    ldm_stm_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".busy"},   32'(bus.busy),      32'd0);
        check_eq({tag, ".rd"},     32'(bus.AHB_rd_en), 32'd0);
        check_eq({tag, ".wr"},     32'(bus.AHB_wr_en), 32'd0);
        check_eq({tag, ".addr"},   bus.AHB_addr,       32'd0);
        check_eq({tag, ".reg"},    32'(bus.xfer_reg),  32'd0);
        check_eq({tag, ".wb_en"},  32'(bus.wb_en),     32'd0);
        check_eq({tag, ".wb_id"},  32'(bus.wb_id),     32'd0);
        check_eq({tag, ".wb_dat"}, bus.wb_data,        32'd0);
        check_eq({tag, ".done"},   32'(bus.done),      32'd0);
        check_eq({tag, ".branch"}, 32'(bus.branch),    32'd0);
    endtask

    // One transaction: expected beats derived from the block-transfer rules.
    task automatic run_txn(input string tag, input logic [15:0] list, input logic [3:0] rn,
                           input logic [31:0] base, input logic p, input logic u,
                           input logic w, input logic l, input int stall_pct,
                           input int max_stall);
        int          regs[$];
        int          n;
        logic [31:0] lo;
        logic [31:0] fin;
        logic        wb_exp;
        logic        pc_seen;
        logic        br_exp;
        logic        ready;
        int          idx;
        int          stalls;

        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        n       = regs.size();
        lo      = u ? base + (p ? 32'd4 : 32'd0) : base - 32'(4 * n) + (p ? 32'd0 : 32'd4);
        fin     = u ? base + 32'(4 * n) : base - 32'(4 * n);
        wb_exp  = w && (n != 0) && !(l && list[rn]);
        pc_seen = 1'b0;

        bus.start = 1'b1; bus.reg_list = list; bus.rn = rn; bus.base = base;
        bus.ldr_p = p; bus.ldr_u = u; bus.ldr_w = w; bus.ldr_l = l;
        @(negedge clk);
        bus.start = 1'b0;

        idx = 0;
        stalls = 0;
        while (idx < n) begin
`ifdef LDMSEQ_PC_LOAD_EN
            br_exp = pc_seen;
`else
            br_exp = 1'b0;
`endif
            check_eq({tag, ".busy"},   32'(bus.busy),      32'd1);
            check_eq({tag, ".rd"},     32'(bus.AHB_rd_en), 32'(l));
            check_eq({tag, ".wr"},     32'(bus.AHB_wr_en), 32'(!l));
            check_eq({tag, ".addr"},   bus.AHB_addr,       lo + 32'(4 * idx));
            check_eq({tag, ".reg"},    32'(bus.xfer_reg),  32'(regs[idx]));
            check_eq({tag, ".wb_en"},  32'(bus.wb_en),     32'd0);
            check_eq({tag, ".done"},   32'(bus.done),      32'd0);
            check_eq({tag, ".branch"}, 32'(bus.branch),    32'(br_exp));
            ready  = (stalls >= max_stall) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
            stalls = ready ? 0 : stalls + 1;
            bus.bus_ready = ready;
            // Stray requests while busy must be ignored.
            bus.start    = ($urandom_range(3) == 0);
            bus.reg_list = 16'($urandom);
            bus.base     = $urandom;
            bus.rn       = 4'($urandom);
            @(negedge clk);
            if (ready) begin
                if (l && regs[idx] == 15) pc_seen = 1'b1;
                idx++;
            end
        end
        bus.start = 1'b0;
        bus.bus_ready = 1'b0;
`ifdef LDMSEQ_PC_LOAD_EN
        br_exp = pc_seen;
`else
        br_exp = 1'b0;
`endif
        if (wb_exp) begin
            check_eq({tag, ".wb_en"},  32'(bus.wb_en),     32'd1);
            check_eq({tag, ".wb_id"},  32'(bus.wb_id),     {28'd0, rn});
            check_eq({tag, ".wb_dat"}, bus.wb_data,        fin);
            check_eq({tag, ".wb_rd"},  32'(bus.AHB_rd_en | bus.AHB_wr_en), 32'd0);
            check_eq({tag, ".wb_dn"},  32'(bus.done),      32'd0);
            check_eq({tag, ".wb_br"},  32'(bus.branch),    32'(br_exp));
            @(negedge clk);
        end
        check_eq({tag, ".done"},    32'(bus.done),      32'd1);
        check_eq({tag, ".dn_busy"}, 32'(bus.busy),      32'd1);
        check_eq({tag, ".dn_strb"}, 32'(bus.AHB_rd_en | bus.AHB_wr_en | bus.wb_en), 32'd0);
        check_eq({tag, ".dn_br"},   32'(bus.branch),    32'(br_exp));
        @(negedge clk);
        check_eq({tag, ".post_busy"}, 32'(bus.busy),   32'd0);
        check_eq({tag, ".post_done"}, 32'(bus.done),   32'd0);
        check_eq({tag, ".post_br"},   32'(bus.branch), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.reg_list = 16'd0; bus.rn = 4'd0; bus.base = 32'd0;
        bus.ldr_p = 1'b0; bus.ldr_u = 1'b0; bus.ldr_w = 1'b0; bus.ldr_l = 1'b0;
        bus.bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        run_txn("ldmia_wb",  16'b0000_0000_0010_0110, 4'd0,  32'h1000, 0, 1, 1, 1, 0, 0);
        run_txn("stmdb_wb",  16'b0100_0000_0001_0000, 4'd13, 32'h2000, 1, 0, 1, 0, 0, 0);
        run_txn("ldmib_stl", 16'b0000_0000_0000_0001, 4'd3,  32'h0040, 1, 1, 0, 1, 100, 2);
        run_txn("empty",     16'd0,                   4'd5,  32'h0800, 0, 1, 1, 1, 0, 0);
        run_txn("ldm_rn_in", 16'b0000_0000_0001_1000, 4'd4,  32'h0100, 0, 1, 1, 1, 0, 0);
        run_txn("stmda",     16'b1000_0000_0000_0011, 4'd2,  32'h0300, 0, 0, 1, 0, 0, 0);
        run_txn("wrap",      16'b0000_0000_1111_0000, 4'd1,  32'hFFFF_FFF8, 0, 1, 1, 0, 0, 0);
        run_txn("pc_load",   16'b1000_0000_0000_0001, 4'd1,  32'h0200, 0, 1, 0, 1, 0, 0);

        // Abort during the second beat of a 4-register STMIA.
        bus.start = 1'b1; bus.reg_list = 16'h00F0; bus.rn = 4'd2; bus.base = 32'h3000;
        bus.ldr_p = 1'b0; bus.ldr_u = 1'b1; bus.ldr_w = 1'b1; bus.ldr_l = 1'b0;
        bus.bus_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("abort.beat1", bus.AHB_addr, 32'h3000);
        @(negedge clk);
        check_eq("abort.beat2", bus.AHB_addr, 32'h3004);
        check_eq("abort.reg2",  32'(bus.xfer_reg), 32'd5);
        rst = 1'b1;
        #1;
        check_idle("abort");
        @(negedge clk);
        check_idle("abort_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_rel");
        run_txn("after_rst", 16'b0000_0000_0000_1100, 4'd6, 32'h5000, 0, 1, 1, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] lst;
            logic [31:0] b;
            lst = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom);
            b   = $urandom & 32'hFFFF_FFFC;
            run_txn("rand", lst, 4'($urandom), b, 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 30, 3);
            if ($urandom_range(1) == 1) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
